pic_8259_lite: RTL

Simplified 8259A-style programmable interrupt controller for the 8088 system. It latches rising edges on the external interrupt request lines and raises `int` to the CPU. It answers the CPU's two-pulse INTA sequence with an 8-bit vector, and tracks in-service levels until software issues EOI. It sits on the CPU I/O bus beside the PIT, selected by the address decoder through `cs`.

---
 rtl/pic_8259_lite.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/pic_8259_lite.sv
// pic_8259_lite: simplified 8259A-style interrupt controller for the 8088 bus.
// Latches rising edges on ir[7:0], raises intr to the CPU, answers the
// two-pulse INTA handshake with {BASE, level} and tracks in-service levels
// until software issues EOI. IR0 has the highest priority.
// The CPU interrupt output is named intr because `int` is a reserved word.
module pic_8259_lite #(
  parameter logic [7:0] VEC_BASE_RST = 8'h08
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       wr,
  input  logic       rd,
  input  logic       a0,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] ir,
  input  logic       inta_n,
  output logic       intr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    GAP  = 2'd2,
    ACK2 = 2'd3
  } inta_state_t;

  inta_state_t state, state_next;

  logic [7:0] irr, isr, imr;
  logic [4:0] base;
  logic       rsel;
  logic       init;
  logic [7:0] ir_q;
  logic       inta_q;
  logic [2:0] lvl;
  logic       spur;

  logic [7:0] req;
  logic [3:0] req_idx, isr_idx;
  logic       int_next;
  logic [7:0] edge_set;
  logic       inta_fall;

  logic       wr_en, icw1, icw2, ocw1, ocw2, ocw3;
  logic [7:0] eoi_clr;
  logic [7:0] ack_set, ack_clr;
  logic       lvl_load, vec_load;

  // Index of the lowest set bit; 8 when the vector is empty.
  function automatic logic [3:0] lowest_idx(input logic [7:0] v);
    logic [3:0] idx;
    idx = 4'd8;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[i] && idx == 4'd8) idx = 4'(i);
    end
    return idx;
  endfunction

  // Request qualification, priority comparison and strobe decode.
  always_comb begin
    req       = irr & ~imr;
    req_idx   = lowest_idx(req);
    isr_idx   = lowest_idx(isr);
    int_next  = (req != 8'h00) && (req_idx < isr_idx);
    edge_set  = ir & ~ir_q;
    inta_fall = inta_q & ~inta_n;
    wr_en     = cs & wr;
    icw1      = wr_en & ~a0 & din[4];
    icw2      = wr_en &  a0 & init;
    ocw1      = wr_en &  a0 & ~init;
    ocw2      = wr_en & ~a0 & (din[4:3] == 2'b00);
    ocw3      = wr_en & ~a0 & (din[4:3] == 2'b01);
  end

  // EOI decode: non-specific clears the lowest set ISR bit, specific the named one.
  always_comb begin
    eoi_clr = '0;
    if (ocw2) begin
      case (din[7:5])
        3'b001:  eoi_clr = isr & (~isr + 8'd1);
        3'b011:  eoi_clr = 8'(1) << din[2:0];
        default: eoi_clr = '0;
      endcase
    end
  end

  // INTA handshake state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // INTA next-state and acknowledge actions; ICW1 cancels everything in flight.
  always_comb begin
    state_next = state;
    ack_set    = '0;
    ack_clr    = '0;
    lvl_load   = 1'b0;
    vec_load   = 1'b0;
    case (state)
      IDLE: if (inta_fall) begin
        state_next = ACK1;
        lvl_load   = 1'b1;
        if (req != 8'h00) begin
          ack_set = 8'(1) << req_idx[2:0];
          ack_clr = 8'(1) << req_idx[2:0];
        end
      end
      ACK1: if (inta_n) state_next = GAP;
      GAP: if (inta_fall) begin
        state_next = ACK2;
        vec_load   = 1'b1;
      end
      ACK2: if (inta_n) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (icw1) begin
      state_next = IDLE;
      ack_set    = '0;
      ack_clr    = '0;
      lvl_load   = 1'b0;
      vec_load   = 1'b0;
    end
  end

  // Programmable registers; a new edge on the acknowledged bit wins over the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irr  <= '0;
      isr  <= '0;
      imr  <= '1;
      base <= VEC_BASE_RST[7:3];
      init <= 1'b0;
      rsel <= 1'b0;
    end else if (icw1) begin
      irr  <= '0;
      isr  <= '0;
      imr  <= '0;
      init <= 1'b1;
      rsel <= 1'b0;
    end else begin
      irr <= (irr & ~ack_clr) | edge_set;
      isr <= (isr & ~eoi_clr) | ack_set;
      if (icw2) begin
        base <= din[7:3];
        init <= 1'b0;
      end
      if (ocw1) imr <= din;
      if (ocw3 && din[1]) rsel <= din[0];
    end
  end

  // Level captured on the first INTA pulse, used for the vector on the second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl  <= '0;
      spur <= 1'b0;
    end else if (lvl_load) begin
      lvl  <= req_idx[2:0];
      spur <= (req == 8'h00);
    end
  end

  // Input history for edge detection on ir and inta_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q   <= '0;
      inta_q <= 1'b1;
    end else begin
      ir_q   <= ir;
      inta_q <= inta_n;
    end
  end

  // Registered read/vector data and interrupt output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      intr <= 1'b0;
    end else begin
      intr <= int_next;
      if (vec_load)       dout <= {base, (spur ? 3'd7 : lvl)};
      else if (cs && rd)  dout <= a0 ? imr : (rsel ? isr : irr);
    end
  end

endmodule
